// File: rtl/tdc_evmerge.sv
// Two-channel TDC event merger: round-robin arbitration into a shared event FIFO,
// a four-register CSR page and a level interrupt while events are pending.
module tdc_evmerge #(
    parameter logic [3:0] csr_addr        = 4'h2,
    parameter int         fifo_depth_log2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ch0_valid,
    input  logic        ch1_valid,
    input  logic [31:0] ch0_ts,
    input  logic [31:0] ch1_ts,
    input  logic        ch0_pol,
    input  logic        ch1_pol,
    output logic        ch0_ready,
    output logic        ch1_ready,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq_o
);
    localparam int DEPTH = 1 << fifo_depth_log2;
    localparam int LW    = fifo_depth_log2;
    localparam logic [LW:0] FULL_LVL = {1'b1, {LW{1'b0}}};

    logic [33:0]   r_mem [DEPTH];
    logic [LW-1:0] r_wptr;
    logic [LW-1:0] r_rptr;
    logic [LW:0]   r_level;
    logic [2:0]    r_ctrl;
    logic          r_ovf;
    logic          r_last;
    logic          r_irq;
    logic [31:0]   r_csr_do;

    logic          w_sel;
    logic          w_empty;
    logic          w_full;
    logic          w_v0;
    logic          w_v1;
    logic          w_gnt;
    logic          w_pop;
    logic          w_room;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ctrl_we;
    logic          w_stat_we;
    logic [33:0]   w_head;
    logic [33:0]   w_push_data;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_sel     = (csr_a[13:10] == csr_addr);
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == FULL_LVL);
    assign w_ctrl_we = w_sel & csr_we & (csr_a[1:0] == 2'd0);
    assign w_stat_we = w_sel & csr_we & (csr_a[1:0] == 2'd1);
    assign w_pop     = w_sel & csr_we & (csr_a[1:0] == 2'd3) & ~w_empty;

    assign w_v0 = ch0_valid & r_ctrl[0];
    assign w_v1 = ch1_valid & r_ctrl[1];

    // On a tie the channel not granted last wins; otherwise whichever is valid.
    assign w_gnt = (w_v0 & w_v1) ? ~r_last : w_v1;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_room    = ~w_full | w_pop;
    assign w_push    = (w_v0 | w_v1) & w_room;
    assign w_ovf_set = (w_v0 | w_v1) & ~w_room;

    assign w_push_data = w_gnt ? {1'b1, ch1_pol, ch1_ts} : {1'b0, ch0_pol, ch0_ts};
    assign w_head      = r_mem[r_rptr];

    assign ch0_ready = ~r_ctrl[0] | (w_push & ~w_gnt);
    assign ch1_ready = ~r_ctrl[1] | (w_push &  w_gnt);

    always_comb begin
        w_rdata = 32'h0;
        case (csr_a[1:0])
            2'd0: w_rdata = {29'h0, r_ctrl};
            2'd1: w_rdata = 32'(r_level) | {23'h0, r_ovf, 8'h0};
            2'd2: w_rdata = w_empty ? 32'h0 : w_head[31:0];
            2'd3: w_rdata = w_empty ? 32'h0 : {1'b1, 29'h0, w_head[33:32]};
            default: w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_push_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_ctrl   <= 3'h0;
            r_ovf    <= 1'b0;
            r_last   <= 1'b1;
            r_irq    <= 1'b0;
            r_csr_do <= 32'h0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LW'(1);
                r_last <= w_gnt;
            end
            if (w_pop)
                r_rptr <= r_rptr + LW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (LW+1)'(1);
                2'b01:   r_level <= r_level - (LW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_ctrl_we)
                r_ctrl <= csr_di[2:0];
            // A new overflow in the same cycle as the clear keeps the flag set.
            r_ovf    <= w_ovf_set | (r_ovf & ~(w_stat_we & csr_di[8]));
            r_irq    <= r_ctrl[2] & ~w_empty;
            r_csr_do <= w_sel ? w_rdata : 32'h0;
        end
    end

    assign csr_do = r_csr_do;
    assign irq_o  = r_irq;

    assign w_unused = ^{csr_a[9:2], csr_di[31:9], csr_di[7:3]};
endmodule

// File: tb/tb_tdc_evmerge.sv
// Bench for tdc_evmerge: queue-based event model checked every cycle, plus
// directed scenarios with literal expected register values.
module tb_tdc_evmerge;
    localparam int DEPTH = 16;
    localparam logic [13:0] A_CTRL = 14'h800;
    localparam logic [13:0] A_STAT = 14'h801;
    localparam logic [13:0] A_TS   = 14'h802;
    localparam logic [13:0] A_TAG  = 14'h803;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        ch0_valid = 1'b0;
    logic        ch1_valid = 1'b0;
    logic [31:0] ch0_ts    = 32'h0;
    logic [31:0] ch1_ts    = 32'h0;
    logic        ch0_pol   = 1'b0;
    logic        ch1_pol   = 1'b0;
    logic        ch0_ready;
    logic        ch1_ready;
    logic [13:0] csr_a     = 14'h0;
    logic        csr_we    = 1'b0;
    logic [31:0] csr_di    = 32'h0;
    logic [31:0] csr_do;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 sys_clk = ~sys_clk;

    tdc_evmerge #(.csr_addr(4'h2), .fifo_depth_log2(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .ch0_valid(ch0_valid), .ch1_valid(ch1_valid),
        .ch0_ts(ch0_ts), .ch1_ts(ch1_ts),
        .ch0_pol(ch0_pol), .ch1_pol(ch1_pol),
        .ch0_ready(ch0_ready), .ch1_ready(ch1_ready),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
        .irq_o(irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: events as {channel, pol, ts} in arrival order.
    logic [33:0] m_q[$];
    logic [2:0]  m_ctrl = 3'h0;
    logic        m_ovf  = 1'b0;
    logic        m_last = 1'b1;
    logic        m_irq  = 1'b0;
    logic [31:0] m_do   = 32'h0;
    logic        e_r0, e_r1, e_push, e_ch, e_ovf, e_pop;

    task automatic model_eval();
        logic want0, want1;
        bit   sel;
        want0 = ch0_valid && m_ctrl[0];
        want1 = ch1_valid && m_ctrl[1];
        sel   = (csr_a[13:10] == 4'h2);
        e_pop = csr_we && sel && (csr_a[1:0] == 2'd3) && (m_q.size() != 0);
        if (want0 && want1) e_ch = (m_last == 1'b0);
        else if (want1)     e_ch = 1'b1;
        else                e_ch = 1'b0;
        e_push = (want0 || want1) && ((m_q.size() < DEPTH) || e_pop);
        e_ovf  = (want0 || want1) && !e_push;
        e_r0   = !m_ctrl[0] || (e_push && !e_ch);
        e_r1   = !m_ctrl[1] || (e_push && e_ch);
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            2'd0: v = {29'h0, m_ctrl};
            2'd1: v = (32'(m_ovf) << 8) | 32'(m_q.size());
            2'd2: if (m_q.size() != 0) v = m_q[0][31:0];
            2'd3: if (m_q.size() != 0) v = {1'b1, 29'h0, m_q[0][33:32]};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_q.delete();
            m_ctrl = 3'h0;
            m_ovf  = 1'b0;
            m_last = 1'b1;
            m_irq  = 1'b0;
            m_do   = 32'h0;
        end else begin
            model_eval();
            m_do  = (csr_a[13:10] == 4'h2) ? model_read(csr_a[1:0]) : 32'h0;
            m_irq = m_ctrl[2] && (m_q.size() != 0);
            if (e_pop) void'(m_q.pop_front());
            if (e_push) begin
                m_q.push_back(e_ch ? {1'b1, ch1_pol, ch1_ts} : {1'b0, ch0_pol, ch0_ts});
                m_last = e_ch;
            end
            if (csr_we && csr_a[13:10] == 4'h2 && csr_a[1:0] == 2'd0) m_ctrl = csr_di[2:0];
            if (csr_we && csr_a[13:10] == 4'h2 && csr_a[1:0] == 2'd1 && csr_di[8]) m_ovf = 1'b0;
            if (e_ovf) m_ovf = 1'b1;
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            model_eval();
            chk("ch0_ready", 32'(ch0_ready), 32'(e_r0));
            chk("ch1_ready", 32'(ch1_ready), 32'(e_r1));
            chk("irq_o", 32'(irq_o), 32'(m_irq));
            chk("csr_do", csr_do, m_do);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
        csr_a = a; csr_we = 1'b1; csr_di = d;
        tick();
        csr_a = 14'h0; csr_we = 1'b0; csr_di = 32'h0;
    endtask

    task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
        csr_a = a;
        tick();
        d = csr_do;
        csr_a = 14'h0;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_ts  [4] = '{32'h10, 32'h21, 32'h12, 32'h23};
    logic [31:0] exp_tag [4] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0001, 32'h8000_0002};

    initial begin
        #3 sys_rst_n = 1'b0;
        #19 sys_rst_n = 1'b1;
        chk("rst ch0_ready", 32'(ch0_ready), 32'h1);
        chk("rst ch1_ready", 32'(ch1_ready), 32'h1);
        chk("rst irq_o", 32'(irq_o), 32'h0);
        chk("rst csr_do", csr_do, 32'h0);
        cmp_en = 1'b1;
        tick();
        csr_rd(A_CTRL, rd); chk("rst CTRL", rd, 32'h0);
        csr_rd(A_STAT, rd); chk("rst STAT", rd, 32'h0);

        // Write to another page must not touch this block.
        csr_wr(14'h000, 32'h7);
        csr_rd(A_CTRL, rd); chk("other page CTRL", rd, 32'h0);

        // Both channels contending for four cycles.
        csr_wr(A_CTRL, 32'h3);
        for (int i = 0; i < 4; i++) begin
            ch0_valid = 1'b1; ch1_valid = 1'b1;
            ch0_ts = 32'h10 + 32'(i); ch1_ts = 32'h20 + 32'(i);
            ch0_pol = 1'b1; ch1_pol = 1'b0;
            tick();
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        csr_rd(A_STAT, rd); chk("rr level", rd, 32'h4);
        for (int k = 0; k < 4; k++) begin
            csr_rd(A_TS, rd);  chk("rr head_ts", rd, exp_ts[k]);
            csr_rd(A_TAG, rd); chk("rr head_tag", rd, exp_tag[k]);
            csr_wr(A_TAG, 32'h0);
        end
        csr_rd(A_STAT, rd); chk("rr drained", rd, 32'h0);

        // Disabled channel is always ready and its events vanish.
        csr_wr(A_CTRL, 32'h1);
        ch1_valid = 1'b1; ch1_ts = 32'h55;
        #1 chk("disabled ch1_ready", 32'(ch1_ready), 32'h1);
        tick();
        ch1_valid = 1'b0;
        csr_rd(A_STAT, rd); chk("disabled level", rd, 32'h0);

        // Fill past capacity.
        for (int i = 0; i < 17; i++) begin
            ch0_valid = 1'b1; ch0_ts = 32'h100 + 32'(i); ch0_pol = i[0];
            if (i == 16) begin
                #1 chk("full ch0_ready", 32'(ch0_ready), 32'h0);
            end
            tick();
        end
        ch0_valid = 1'b0;
        csr_rd(A_STAT, rd); chk("full STAT", rd, 32'h110);
        csr_wr(A_STAT, 32'h100);
        csr_rd(A_STAT, rd); chk("ovf cleared", rd, 32'h010);

        // Push and pop together while full.
        ch0_valid = 1'b1; ch0_ts = 32'h999; ch0_pol = 1'b1;
        csr_a = A_TAG; csr_we = 1'b1;
        #1 chk("full pop ch0_ready", 32'(ch0_ready), 32'h1);
        tick();
        ch0_valid = 1'b0; csr_a = 14'h0; csr_we = 1'b0;
        csr_rd(A_STAT, rd); chk("full pushpop level", rd, 32'h10);
        csr_rd(A_TS, rd);   chk("full pushpop head", rd, 32'h101);
        for (int i = 0; i < 15; i++) csr_wr(A_TAG, 32'h0);
        csr_rd(A_TS, rd);  chk("tail ts", rd, 32'h999);
        csr_rd(A_TAG, rd); chk("tail tag", rd, 32'h8000_0001);
        csr_wr(A_TAG, 32'h0);
        csr_rd(A_STAT, rd); chk("empty again", rd, 32'h0);
        csr_wr(A_TAG, 32'h0);
        csr_rd(A_STAT, rd); chk("pop empty noop", rd, 32'h0);

        // Interrupt path.
        csr_wr(A_CTRL, 32'h5);
        ch0_valid = 1'b1; ch0_ts = 32'hABCD_1234; ch0_pol = 1'b1;
        tick();
        ch0_valid = 1'b0;
        chk("irq after 1", 32'(irq_o), 32'h0);
        tick();
        chk("irq after 2", 32'(irq_o), 32'h1);
        csr_rd(A_TS, rd);  chk("irq head_ts", rd, 32'hABCD_1234);
        csr_rd(A_TAG, rd); chk("irq head_tag", rd, 32'h8000_0001);
        csr_wr(A_TAG, 32'h0);
        csr_rd(A_TAG, rd); chk("irq tag empty", rd, 32'h0);
        chk("irq cleared", 32'(irq_o), 32'h0);

        // Reset with pending entries.
        csr_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) begin
            ch0_valid = 1'b1; ch0_ts = 32'h300 + 32'(i);
            tick();
        end
        ch0_valid = 1'b0;
        csr_wr(A_CTRL, 32'h5);
        tick();
        chk("pre-rst irq", 32'(irq_o), 32'h1);
        csr_rd(A_STAT, rd); chk("pre-rst level", rd, 32'h5);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst irq", 32'(irq_o), 32'h0);
        chk("midrst csr_do", csr_do, 32'h0);
        chk("midrst ch0_ready", 32'(ch0_ready), 32'h1);
        chk("midrst ch1_ready", 32'(ch1_ready), 32'h1);
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        csr_rd(A_STAT, rd); chk("post-rst STAT", rd, 32'h0);
        csr_rd(A_CTRL, rd); chk("post-rst CTRL", rd, 32'h0);

        // First tie after reset goes to ch0.
        csr_wr(A_CTRL, 32'h3);
        ch0_valid = 1'b1; ch1_valid = 1'b1; ch0_ts = 32'h77; ch1_ts = 32'h88;
        #1;
        chk("tie ch0_ready", 32'(ch0_ready), 32'h1);
        chk("tie ch1_ready", 32'(ch1_ready), 32'h0);
        tick();
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        csr_rd(A_TS, rd); chk("tie head_ts", rd, 32'h77);
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tdc_evmerge.md
TDC_EVMERGE -- requirements
Module: tdc_evmerge

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h2, the CSR page that selects this block (compared with csr_a[13:10]).
REQ-002 SHALL have parameter fifo_depth_log2, default 4, giving a shared event FIFO of 2**fifo_depth_log2 entries.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have ports ch0_valid, ch1_valid, input, 1 each, a channel timestamp is offered.
REQ-006 SHALL have ports ch0_ts, ch1_ts, input, 32 each, the channel timestamps.
REQ-007 SHALL have ports ch0_pol, ch1_pol, input, 1 each, the edge polarity (1 = rising).
REQ-008 SHALL have ports ch0_ready, ch1_ready, output, 1 each, the offered event is accepted this cycle.
REQ-009 SHALL have port csr_a, input, 14, the CSR address.
REQ-010 SHALL have port csr_we, input, 1, the CSR write strobe.
REQ-011 SHALL have port csr_di, input, 32, the CSR write data.
REQ-012 SHALL have port csr_do, output, 32, the CSR read data; it is 0 when the block is not selected, so it can be OR-combined on the bus.
REQ-013 SHALL have port irq_o, output, 1, the event-pending interrupt, level-sensitive.

Function
REQ-014 SHALL implement registers selected by csr_a[1:0] when csr_a[13:10]==csr_addr:
- 0 CTRL (RW): bit0 ch0_en, bit1 ch1_en, bit2 irq_en.
- 1 STAT: [fifo_depth_log2:0] level (RO); bit8 overflow (write 1 to clear).
- 2 HEAD_TS (RO): timestamp of the FIFO head.
- 3 HEAD_TAG: bit31 nonempty, bit1 channel, bit0 polarity on read; any write pops the FIFO.
REQ-015 SHALL register csr_do, so read data appears one cycle after csr_a; unused bits read 0.
REQ-016 SHALL hold a disabled channel's ready at 1 and discard its events; these events are not stored and not counted.
REQ-017 SHALL accept at most one event per cycle (ready asserted combinationally), and only for an enabled channel whose valid=1 while the FIFO is not full.
REQ-018 SHALL arbitrate round-robin:
- Only one enabled valid: grant it.
- Both enabled and valid: grant the channel not granted last.
- Last-grant pointer updates only on an actual grant.
REQ-019 SHALL push {channel, pol, ts} on a grant; the entry is visible in level and HEAD registers on the next cycle.
REQ-020 SHALL hold both enabled readies at 0 while the FIFO is full and any enabled valid is present, and set overflow to 1 in that cycle.
REQ-021 SHALL make a pop on an empty FIFO a no-op; the level does not underflow.
REQ-022 SHALL apply both a push and a pop in the same cycle: level unchanged, correct ordering, including when full (pop frees the slot) and when empty (the empty-case pop is ignored and the push is applied).
REQ-023 SHALL give an overflow set that occurs in the same cycle as a W1C clear priority, so overflow stays 1.
REQ-024 SHALL wrap read and write pointers modulo depth; level ranges 0..2**fifo_depth_log2.
REQ-025 SHALL make HEAD_TS and HEAD_TAG[1:0] read 0 when the FIFO is empty.
REQ-026 SHALL register irq_o = irq_en AND (level != 0).

Reset
REQ-027 SHALL, on sys_rst_n low and asynchronously:
- CTRL = 0, FIFO empty (level 0), overflow = 0.
- Pointers = 0; last-grant = ch1, so ch0 wins the first tie.
- csr_do = 0, irq_o = 0.
REQ-028 SHALL force readies to 1 during reset (channels disabled); FIFO contents need no clearing.
REQ-029 SHALL, on reset assertion mid-operation, discard pending entries and leave no partial push or pop.

Verification
REQ-030 SHALL have a bench cover:
- CTRL=3; ch0 and ch1 valid together for 4 cycles with ts 0x10..0x13 / 0x20..0x23 -> FIFO order ch0, ch1, ch0, ch1; level 4.
- CTRL=1; ch1 valid -> ch1_ready=1, level stays 0.
- CTRL=1; 17 back-to-back ch0 events with depth 16 -> level 16, ch0_ready=0 on the 17th, STAT bit8=1; write 0x100 to STAT -> bit8=0.
- FIFO full, push and HEAD_TAG pop in the same cycle -> level stays 16, old head removed, new entry at tail.
- CTRL=5, one ch0 event ts 0xABCD1234 pol 1 -> irq_o=1 two cycles after valid; HEAD_TS=0xABCD1234, HEAD_TAG=0x80000001; pop -> irq_o=0, HEAD_TAG=0.
- sys_rst_n pulsed low with level 5 -> level 0, CTRL 0, irq_o 0 immediately.
